jtsdram_prog_chk: RTL and testbench
===================================

# jtsdram_prog_chk

Parametrised SDRAM fill-and-check engine; successor to the fixed 4-bank/22-bit programmer. Sweeps every address of every bank through the SDRAM controller's programming port, writing a deterministic seed-based pattern and/or reading it back and comparing. Sits between the test top level and the controller's prog_* port; reports pass/fail, error count and the first failing location.

## Interface
- AW, 22: word address width per bank.
- BAW, 2: bank address width (NB = 2**BAW banks).
- DW, 16: data width; must be 16 when BYTEWR=1.
- BYTEWR, 1: 1 = byte-masked writes (each word written as two byte passes); 0 = full-word writes.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; latches mode and seed, restarts sweep (also when busy).
- mode  in  2  01 write, 10 verify, 11 write then verify, 00 no-op.
- seed  in  DW  pattern seed.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next start.
- fail  out  1  at least one mismatch in the current run.
- err_cnt  out  16  mismatch count, saturates at 0xFFFF.
- err_ba  out  BAW  bank of first mismatch.
- err_addr  out  AW  address of first mismatch.
- prog_addr  out  AW  word address to controller.
- prog_ba  out  BAW  bank to controller.
- prog_data  out  DW  write data.
- prog_mask  out  2  byte mask, 1 = byte not written.
- prog_we  out  1  write request.
- prog_rd  out  1  read request.
- prog_ack  in  1  controller accepted request.
- prog_rdy  in  1  access complete; read data valid.
- prog_dout  in  DW  read data, valid with prog_rdy.

## Operation
- Sweep counter cnt, width BAW+AW+BYTEWR; decoded {ba, addr, half} = cnt (half absent when BYTEWR=0). Bank is outermost.
- Pattern: pat = addr[DW-1:0] ^ (addr >> DW, truncated to DW) ^ rotl(seed, ba). Combinational, from the jtsdram_pattern sub-module.
- States: IDLE, LOAD, REQ, WAIT, NEXT, DONE.
- IDLE: outputs quiet. start -> LOAD; clears cnt, fail, err_cnt, err_ba, err_addr, done; sets busy. Phase = WR if mode[0], else RD. mode=00 -> DONE directly, busy stays 0.
- LOAD: register prog_ba/prog_addr from cnt, prog_data=pat, prog_mask={half,~half} (BYTEWR=1) or 00; assert prog_we (WR) or prog_rd (RD) -> REQ.
- REQ: hold request until prog_ack; on ack, drop request -> WAIT. Ack and rdy in the same cycle: drop request and treat as complete (go to NEXT).
- WAIT: on prog_rdy in RD phase, compare prog_dout against pat on unmasked bytes only (BYTEWR=1: half=0 checks [15:8], half=1 checks [7:0]). Mismatch: err_cnt+1 (saturating); if fail was 0, capture err_ba/err_addr; set fail. -> NEXT.
- NEXT: cnt all-ones -> if phase WR and mode=11, cnt=0, phase RD, -> LOAD; else -> DONE. Otherwise cnt+1 -> LOAD.
- DONE: done=1, busy=0, prog_mask=11, prog_we/prog_rd=0. Stays until start.
- start in any state restarts (same actions as from IDLE); an in-flight request is dropped immediately.

## Timing
- Reset values: all outputs 0 except prog_mask=11; state IDLE; phase WR.
- start sampled at edge n -> LOAD after n; request and address/data valid after edge n+1.
- Per access minimum: LOAD, REQ, (WAIT), NEXT = 3 cycles with same-cycle ack+rdy, 4 otherwise.
- prog_addr/prog_ba/prog_data/prog_mask stable from LOAD exit until NEXT.
- done rises the cycle after NEXT of the final access; busy falls the same cycle.
- prog_ack with no request outstanding: ignored. prog_rdy outside WAIT/REQ: ignored.
- Asynchronous reset mid-sweep returns all state to reset values immediately; no request held.

## Structure
- Shared package jtsdram_pkg: state encoding, mode codes (MODE_WR, MODE_RD, MODE_WRRD), err_cnt width.
- Sub-module jtsdram_pattern (parameters AW, BAW, DW): combinational pat from {ba, addr, seed}; reused by benches as the golden model.

## Test plan
- AW=2, BAW=1, BYTEWR=0, mode=01, seed=0, ack+rdy one cycle after request -> 8 writes, bank 0 data 0,1,2,3; bank 1 data rotl(0,1) ^ addr; done after final NEXT; fail=0.
- Same config, mode=11, memory model echoes writes -> 8 writes then 8 reads, fail=0, err_cnt=0.
- mode=10 with memory word ba=1, addr=2 corrupted to 0xFFFF, seed=0x0001 -> fail=1, err_cnt=1, err_ba=1, err_addr=2.
- BYTEWR=1, AW=1, BAW=0, mode=01 -> 4 accesses, masks 01,10,01,10, each address written twice with identical data.
- Ack delayed 5 cycles, rdy 3 cycles later -> prog_we held exactly until ack; one access per ack/rdy pair.
- rst_n low mid-sweep then start with mode=00 -> all outputs at reset values; next cycle after start, done=1, busy=0, no request issued.

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the SDRAM fill-and-check engine.
package jtsdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_WR,
    PH_RD
  } phase_t;

  localparam logic [1:0] MODE_NOP  = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_WRRD = 2'b11;

  localparam int ERR_W = 16;

endpackage

// File: rtl/jtsdram_pattern.sv
// Deterministic test pattern: address folded to DW bits, xored with the
// seed rotated left by the bank number.
module jtsdram_pattern #(
  parameter int AW  = 22,
  parameter int BAW = 2,
  parameter int DW  = 16
) (
  input  logic [BAW-1:0] ba,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  seed,
  output logic [DW-1:0]  pat
);

  logic [DW-1:0] rot;

  // Rotation done on a doubled seed so a zero rotate needs no special case.
  always_comb begin
    rot = DW'(({seed, seed} << (int'(ba) % DW)) >> DW);
    pat = DW'(addr) ^ DW'(addr >> DW) ^ rot;
  end

endmodule

// File: rtl/jtsdram_prog_chk.sv
// SDRAM fill-and-check engine: sweeps all banks/addresses through the
// controller programming port, writing and/or verifying a seeded pattern.
module jtsdram_prog_chk
  import jtsdram_pkg::*;
#(
  parameter int AW     = 22,
  parameter int BAW    = 2,
  parameter int DW     = 16,
  parameter int BYTEWR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    seed,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [BAW-1:0]   err_ba,
  output logic [AW-1:0]    err_addr,
  output logic [AW-1:0]    prog_addr,
  output logic [BAW-1:0]   prog_ba,
  output logic [DW-1:0]    prog_data,
  output logic [1:0]       prog_mask,
  output logic             prog_we,
  output logic             prog_rd,
  input  logic             prog_ack,
  input  logic             prog_rdy,
  input  logic [DW-1:0]    prog_dout
);

  localparam int CW = BAW + AW + BYTEWR;

  state_t          state, state_nxt;
  phase_t          phase;
  logic [1:0]      mode_r;
  logic [DW-1:0]   seed_r;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   cur_addr;
  logic [BAW-1:0]  cur_ba;
  logic [DW-1:0]   pat;
  logic [1:0]      mask_r;
  logic [1:0]      load_mask;
  logic [DW-1:0]   cmp_mask;
  logic            complete;
  logic            mismatch;
  logic            last;
  logic            wrap_to_rd;

  // Bank is the outermost field of the sweep counter, half-word the innermost.
  assign cur_addr = cnt[BYTEWR +: AW];
  assign cur_ba   = cnt[BYTEWR+AW +: BAW];

  generate
    if (BYTEWR != 0) begin : g_byte
      logic half;
      assign half      = cnt[0];
      assign load_mask = {half, ~half};
      assign cmp_mask  = half ? {{DW/2{1'b0}}, {DW/2{1'b1}}}
                              : {{DW/2{1'b1}}, {DW/2{1'b0}}};
    end else begin : g_word
      assign load_mask = 2'b00;
      assign cmp_mask  = '1;
    end
  endgenerate

  jtsdram_pattern #(
    .AW  (AW),
    .BAW (BAW),
    .DW  (DW)
  ) u_pattern (
    .ba   (cur_ba),
    .addr (cur_addr),
    .seed (seed_r),
    .pat  (pat)
  );

  assign last       = &cnt;
  assign wrap_to_rd = (phase == PH_WR) && (mode_r == MODE_WRRD);
  // An ack arriving together with rdy completes the access directly from REQ.
  assign complete   = ((state == ST_REQ) && prog_ack && prog_rdy) ||
                      ((state == ST_WAIT) && prog_rdy);
  assign mismatch   = complete && (phase == PH_RD) &&
                      (|((prog_dout ^ pat) & cmp_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (mode == MODE_NOP) ? ST_DONE : ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: state_nxt = ST_REQ;
        ST_REQ:  if (prog_ack) state_nxt = prog_rdy ? ST_NEXT : ST_WAIT;
        ST_WAIT: if (prog_rdy) state_nxt = ST_NEXT;
        ST_NEXT: state_nxt = (last && !wrap_to_rd) ? ST_DONE : ST_LOAD;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy      = state inside {ST_LOAD, ST_REQ, ST_WAIT, ST_NEXT};
    done      = (state == ST_DONE);
    prog_we   = (state == ST_REQ) && (phase == PH_WR);
    prog_rd   = (state == ST_REQ) && (phase == PH_RD);
    prog_mask = (state == ST_DONE) ? 2'b11 : mask_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PH_WR;
      mode_r    <= MODE_NOP;
      seed_r    <= '0;
      cnt       <= '0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      err_ba    <= '0;
      err_addr  <= '0;
      prog_ba   <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      mask_r    <= 2'b11;
    end else if (start) begin
      phase    <= mode[0] ? PH_WR : PH_RD;
      mode_r   <= mode;
      seed_r   <= seed;
      cnt      <= '0;
      fail     <= 1'b0;
      err_cnt  <= '0;
      err_ba   <= '0;
      err_addr <= '0;
    end else begin
      if (state == ST_LOAD) begin
        prog_ba   <= cur_ba;
        prog_addr <= cur_addr;
        prog_data <= pat;
        mask_r    <= load_mask;
      end
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        if (!fail) begin
          err_ba   <= cur_ba;
          err_addr <= cur_addr;
        end
        fail <= 1'b1;
      end
      // The final NEXT either turns a write pass into the verify pass or holds.
      if (state == ST_NEXT) begin
        if (!last) begin
          cnt <= cnt + CW'(1);
        end else if (wrap_to_rd) begin
          cnt   <= '0;
          phase <= PH_RD;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtsdram_prog_chk.sv
// Bench for jtsdram_prog_chk: a word-write instance and a byte-write instance,
// each against a behavioural memory, with an expected-access scoreboard.
module tb_jtsdram_prog_chk;

  typedef struct packed {
    logic        we;
    logic        rd;
    logic        ba;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: AW=2, BAW=1, word writes
  logic        a_start = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [15:0] a_seed = 16'h0;
  logic        a_busy, a_done, a_fail;
  logic [15:0] a_err_cnt;
  logic        a_err_ba;
  logic [1:0]  a_err_addr;
  logic [1:0]  a_prog_addr;
  logic        a_prog_ba;
  logic [15:0] a_prog_data;
  logic [1:0]  a_prog_mask;
  logic        a_prog_we, a_prog_rd;
  logic        a_prog_ack = 1'b0;
  logic        a_prog_rdy = 1'b0;
  logic [15:0] a_prog_dout = 16'h0;

  // Instance B: AW=1, BAW=1, byte-masked writes
  logic        b_start = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [15:0] b_seed = 16'h0;
  logic        b_busy, b_done, b_fail;
  logic [15:0] b_err_cnt;
  logic        b_err_ba;
  logic [0:0]  b_err_addr;
  logic [0:0]  b_prog_addr;
  logic        b_prog_ba;
  logic [15:0] b_prog_data;
  logic [1:0]  b_prog_mask;
  logic        b_prog_we, b_prog_rd;
  logic        b_prog_ack = 1'b0;
  logic        b_prog_rdy = 1'b0;
  logic [15:0] b_prog_dout = 16'h0;

  jtsdram_prog_chk #(.AW(2), .BAW(1), .DW(16), .BYTEWR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .seed(a_seed),
    .busy(a_busy), .done(a_done), .fail(a_fail), .err_cnt(a_err_cnt),
    .err_ba(a_err_ba), .err_addr(a_err_addr), .prog_addr(a_prog_addr),
    .prog_ba(a_prog_ba), .prog_data(a_prog_data), .prog_mask(a_prog_mask),
    .prog_we(a_prog_we), .prog_rd(a_prog_rd), .prog_ack(a_prog_ack),
    .prog_rdy(a_prog_rdy), .prog_dout(a_prog_dout)
  );

  jtsdram_prog_chk #(.AW(1), .BAW(1), .DW(16), .BYTEWR(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .seed(b_seed),
    .busy(b_busy), .done(b_done), .fail(b_fail), .err_cnt(b_err_cnt),
    .err_ba(b_err_ba), .err_addr(b_err_addr), .prog_addr(b_prog_addr),
    .prog_ba(b_prog_ba), .prog_data(b_prog_data), .prog_mask(b_prog_mask),
    .prog_we(b_prog_we), .prog_rd(b_prog_rd), .prog_ack(b_prog_ack),
    .prog_rdy(b_prog_rdy), .prog_dout(b_prog_dout)
  );

  acc_t        a_exp[$];
  acc_t        b_exp[$];
  logic [15:0] mem_a[8];
  logic [15:0] mem_b[4];
  int          ack_dly = 0;
  int          rdy_dly = 0;
  int          a_wait = 0;
  bit          a_acked = 1'b0;
  logic [2:0]  a_idx = 3'd0;
  logic [1:0]  b_idx = 2'd0;
  int          a_reqs = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tb_pat(input logic ba, input logic [1:0] addr,
                                         input logic [15:0] seed);
    logic [15:0] rot;
    rot = ba ? {seed[14:0], seed[15]} : seed;
    return {14'd0, addr} ^ rot;
  endfunction

  task automatic pushSweep(input bit inst_b, input logic [1:0] mode,
                           input logic [15:0] seed);
    for (int ph = 0; ph < 2; ph++) begin
      if ((ph == 0 && mode[0]) || (ph == 1 && mode[1])) begin
        for (int ba = 0; ba < 2; ba++) begin
          for (int ad = 0; ad < (inst_b ? 2 : 4); ad++) begin
            for (int h = 0; h < (inst_b ? 2 : 1); h++) begin
              acc_t e;
              e.we   = (ph == 0);
              e.rd   = (ph == 1);
              e.ba   = ba[0];
              e.addr = ad[1:0];
              e.data = tb_pat(ba[0], ad[1:0], seed);
              e.mask = inst_b ? {h[0], ~h[0]} : 2'b00;
              if (inst_b) b_exp.push_back(e);
              else        a_exp.push_back(e);
            end
          end
        end
      end
    end
  endtask

  // Pulse start for one cycle; returns on the negedge after the sampling edge.
  task automatic applyStimulus(input bit inst_b, input logic [1:0] mode,
                               input logic [15:0] seed);
    pushSweep(inst_b, mode, seed);
    if (inst_b) begin
      b_mode = mode; b_seed = seed; b_start = 1'b1;
    end else begin
      a_mode = mode; a_seed = seed; a_start = 1'b1;
    end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic waitDone(input bit inst_b, input int expect_cyc, input string tag);
    int cyc;
    cyc = 1;
    while (!(inst_b ? b_done : a_done) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(expect_cyc));
    checkOutput({tag, "_busy_low"}, 32'(inst_b ? b_busy : a_busy), 0);
    checkOutput({tag, "_queue_empty"}, 32'(inst_b ? b_exp.size() : a_exp.size()), 0);
  endtask

  // Memory model A: programmable ack/rdy latency, checks each accepted request.
  always @(negedge clk) begin
    a_prog_ack = 1'b0;
    a_prog_rdy = 1'b0;
    if (!rst_n) begin
      a_wait  = 0;
      a_acked = 1'b0;
    end else if (a_acked) begin
      checkOutput("a_req_dropped_after_ack", 32'({a_prog_we, a_prog_rd}), 0);
      a_wait++;
      if (a_wait >= rdy_dly) begin
        a_prog_rdy  = 1'b1;
        a_prog_dout = mem_a[a_idx];
        a_acked     = 1'b0;
        a_wait      = 0;
      end
    end else if (a_prog_we || a_prog_rd) begin
      if (a_wait >= ack_dly) begin
        acc_t o;
        a_prog_ack = 1'b1;
        a_reqs++;
        o = '{we: a_prog_we, rd: a_prog_rd, ba: a_prog_ba, addr: a_prog_addr,
              data: a_prog_data, mask: a_prog_mask};
        if (a_exp.size() == 0) checkOutput("a_unexpected_req", 32'(o), 0);
        else                   checkOutput("a_access", 32'(o), 32'(a_exp.pop_front()));
        a_idx = {a_prog_ba, a_prog_addr};
        if (a_prog_we) mem_a[a_idx] = a_prog_data;
        a_wait = 0;
        if (rdy_dly == 0) begin
          a_prog_rdy  = 1'b1;
          a_prog_dout = mem_a[a_idx];
        end else begin
          a_acked = 1'b1;
        end
      end else begin
        a_wait++;
      end
    end
  end

  // Memory model B: ack and rdy together, byte writes honour the mask.
  always @(negedge clk) begin
    b_prog_ack = 1'b0;
    b_prog_rdy = 1'b0;
    if (rst_n && (b_prog_we || b_prog_rd)) begin
      acc_t o;
      b_prog_ack = 1'b1;
      b_prog_rdy = 1'b1;
      o = '{we: b_prog_we, rd: b_prog_rd, ba: b_prog_ba, addr: {1'b0, b_prog_addr},
            data: b_prog_data, mask: b_prog_mask};
      if (b_exp.size() == 0) checkOutput("b_unexpected_req", 32'(o), 0);
      else                   checkOutput("b_access", 32'(o), 32'(b_exp.pop_front()));
      b_idx = {b_prog_ba, b_prog_addr};
      if (b_prog_we) begin
        if (!b_prog_mask[0]) mem_b[b_idx][7:0]  = b_prog_data[7:0];
        if (!b_prog_mask[1]) mem_b[b_idx][15:8] = b_prog_data[15:8];
      end
      b_prog_dout = mem_b[b_idx];
    end
  end

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_busy"}, 32'(a_busy), 0);
    checkOutput({tag, "_done"}, 32'(a_done), 0);
    checkOutput({tag, "_fail"}, 32'(a_fail), 0);
    checkOutput({tag, "_err_cnt"}, 32'(a_err_cnt), 0);
    checkOutput({tag, "_err_loc"}, 32'({a_err_ba, a_err_addr}), 0);
    checkOutput({tag, "_prog_loc"}, 32'({a_prog_ba, a_prog_addr}), 0);
    checkOutput({tag, "_prog_data"}, 32'(a_prog_data), 0);
    checkOutput({tag, "_prog_mask"}, 32'(a_prog_mask), 32'h3);
    checkOutput({tag, "_prog_req"}, 32'({a_prog_we, a_prog_rd}), 0);
  endtask

  initial begin
    int base_reqs;
    for (int i = 0; i < 8; i++) mem_a[i] = 16'h0;
    for (int i = 0; i < 4; i++) mem_b[i] = 16'h5A5A;
    repeat (2) @(negedge clk);
    checkResetA("reset");
    checkOutput("reset_b_mask", 32'(b_prog_mask), 32'h3);
    rst_n = 1'b1;

    // Write sweep, seed 0: 8 accesses of 3 cycles each
    applyStimulus(1'b0, 2'b01, 16'h0000);
    checkOutput("wr_busy_after_start", 32'(a_busy), 1);
    checkOutput("wr_done_after_start", 32'(a_done), 0);
    waitDone(1'b0, 25, "wr_seed0");
    checkOutput("wr_seed0_fail", 32'(a_fail), 0);
    checkOutput("wr_seed0_done_mask", 32'(a_prog_mask), 32'h3);

    // Write then verify against the echoing memory
    applyStimulus(1'b0, 2'b11, 16'h0000);
    waitDone(1'b0, 49, "wrrd_seed0");
    checkOutput("wrrd_fail", 32'(a_fail), 0);
    checkOutput("wrrd_err_cnt", 32'(a_err_cnt), 0);

    // Verify only, one corrupted word at bank 1 address 2
    for (int i = 0; i < 8; i++) mem_a[i] = tb_pat(i[2], i[1:0], 16'h0001);
    mem_a[6] = 16'hFFFF;
    applyStimulus(1'b0, 2'b10, 16'h0001);
    waitDone(1'b0, 25, "rd_corrupt1");
    checkOutput("rd_corrupt1_fail", 32'(a_fail), 1);
    checkOutput("rd_corrupt1_err_cnt", 32'(a_err_cnt), 1);
    checkOutput("rd_corrupt1_err_ba", 32'(a_err_ba), 1);
    checkOutput("rd_corrupt1_err_addr", 32'(a_err_addr), 2);

    // Slow controller: ack 5 cycles late, rdy 3 cycles after ack
    ack_dly = 5;
    rdy_dly = 3;
    applyStimulus(1'b0, 2'b01, 16'hA5C3);
    waitDone(1'b0, 89, "wr_slow");
    ack_dly = 0;
    rdy_dly = 0;

    // Two corrupted words: the first in sweep order is reported
    mem_a[5] = mem_a[5] ^ 16'h0040;
    mem_a[3] = mem_a[3] ^ 16'h1000;
    applyStimulus(1'b0, 2'b10, 16'hA5C3);
    waitDone(1'b0, 25, "rd_corrupt2");
    checkOutput("rd_corrupt2_err_cnt", 32'(a_err_cnt), 2);
    checkOutput("rd_corrupt2_err_loc", 32'({a_err_ba, a_err_addr}), 32'h3);

    // Restart mid-sweep from a LOAD cycle; start clears error state
    applyStimulus(1'b0, 2'b01, 16'h1111);
    checkOutput("restart_fail_cleared", 32'(a_fail), 0);
    checkOutput("restart_err_cleared", 32'(a_err_cnt), 0);
    repeat (9) @(negedge clk);
    a_exp.delete();
    applyStimulus(1'b0, 2'b01, 16'h3C5A);
    checkOutput("restart_busy", 32'(a_busy), 1);
    waitDone(1'b0, 25, "restart");

    // Asynchronous reset during a slow verify that has already failed
    mem_a[0] = mem_a[0] ^ 16'h8000;
    ack_dly = 5;
    rdy_dly = 3;
    applyStimulus(1'b0, 2'b10, 16'h3C5A);
    repeat (19) @(negedge clk);
    checkOutput("midsweep_fail_seen", 32'(a_fail), 1);
    rst_n = 1'b0;
    #1;
    checkResetA("async_reset");
    a_exp.delete();
    ack_dly = 0;
    rdy_dly = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base_reqs = a_reqs;
    applyStimulus(1'b0, 2'b00, 16'h0000);
    checkOutput("nop_done", 32'(a_done), 1);
    checkOutput("nop_busy", 32'(a_busy), 0);
    repeat (4) @(negedge clk);
    checkOutput("nop_no_request", 32'(a_reqs - base_reqs), 0);
    checkOutput("nop_done_held", 32'(a_done), 1);

    // Byte-masked instance: write then verify, two passes per word
    applyStimulus(1'b1, 2'b11, 16'h1234);
    waitDone(1'b1, 49, "b_wrrd");
    checkOutput("b_wrrd_fail", 32'(b_fail), 0);
    for (int i = 0; i < 4; i++)
      checkOutput("b_mem_word", 32'(mem_b[i]), 32'(tb_pat(i[1], {1'b0, i[0]}, 16'h1234)));

    // Low byte corrupted: only the half=1 pass may see it
    mem_b[2] = mem_b[2] ^ 16'h0011;
    applyStimulus(1'b1, 2'b10, 16'h1234);
    waitDone(1'b1, 25, "b_rd_low");
    checkOutput("b_rd_low_err_cnt", 32'(b_err_cnt), 1);
    checkOutput("b_rd_low_err_loc", 32'({b_err_ba, b_err_addr}), 32'h2);

    // High byte of an earlier word also corrupted
    mem_b[1] = mem_b[1] ^ 16'h0100;
    applyStimulus(1'b1, 2'b10, 16'h1234);
    waitDone(1'b1, 25, "b_rd_two");
    checkOutput("b_rd_two_fail", 32'(b_fail), 1);
    checkOutput("b_rd_two_err_cnt", 32'(b_err_cnt), 2);
    checkOutput("b_rd_two_err_loc", 32'({b_err_ba, b_err_addr}), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
